rmgmt_mem_arbiter: RTL

RMGMT_MEM_ARBITER -- requirements
Module: rmgmt_mem_arbiter

---
 rtl/rmgmt_mem_arbiter.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/rmgmt_mem_arbiter.sv
// rmgmt_mem_arbiter
// Shares the single RISC-MGMT memory port between N_EXT extension requesters.
// One access is in flight at a time: IDLE picks a winner and latches its
// request, BUSY presents it to the pipeline until mem_busy drops, and DONE
// pulses ext_done to the winner for one cycle.
// Requests that assert both or neither of ren/wen are rejected with a
// single-cycle ext_err pulse and are never granted.
// Optional feature macro: RMGMT_ARB_RR_EN selects round-robin arbitration.
// When it is undefined, the lowest index wins (fixed priority).

module rmgmt_mem_arbiter #(
   parameter int N_EXT = 4
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic [N_EXT-1:0]     ext_req,
   input  logic [N_EXT-1:0]     ext_ren,
   input  logic [N_EXT-1:0]     ext_wen,
   input  logic [N_EXT*32-1:0]  ext_addr,
   input  logic [N_EXT*32-1:0]  ext_store,
   output logic [N_EXT-1:0]     ext_gnt,
   output logic [N_EXT-1:0]     ext_done,
   output logic [N_EXT-1:0]     ext_err,
   output logic [31:0]          ext_load,
   output logic                 req_mem,
   output logic                 mem_ren,
   output logic                 mem_wen,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_store,
   input  logic [31:0]          mem_load,
   input  logic                 mem_busy,
   output logic                 memory_stall
);

   localparam int IDX_W = $clog2(N_EXT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } arb_state_e;

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] winIdx_q, winIdx_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      store_q, store_d;
   logic [31:0]      load_q, load_d;
   logic             ren_q, ren_d;
   logic             wen_q, wen_d;
   logic [N_EXT-1:0] errSeen_q, errSeen_d;

   logic [N_EXT-1:0] legalReq;
   logic [N_EXT-1:0] validReq;
   logic [N_EXT-1:0] illegalReq;
   logic [N_EXT-1:0] errPulse;
   logic             anyValid;
   logic [IDX_W-1:0] selIdx;

`ifdef RMGMT_ARB_RR_EN
   logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
   int               rrCand;
`endif

   // A request is only legal when exactly one of read/write is selected.
   always_comb begin
      legalReq   = ext_ren ^ ext_wen;
      validReq   = ext_req & legalReq;
      illegalReq = ext_req & ~legalReq;
   end

`ifdef RMGMT_ARB_RR_EN
   // Round-robin search starting at the pointer, wrapping at N_EXT.
   always_comb begin
      anyValid = 1'b0;
      selIdx   = '0;
      rrCand   = 0;
      for (int k = 0; k < N_EXT; k++) begin
         rrCand = int'(rrPtr_q) + k;
         if (rrCand >= N_EXT) begin
            rrCand = rrCand - N_EXT;
         end
         if (!anyValid && validReq[rrCand]) begin
            anyValid = 1'b1;
            selIdx   = IDX_W'(rrCand);
         end
      end
   end

   // Pointer moves just past the requester granted this cycle.
   always_comb begin
      rrPtr_d = rrPtr_q;
      if (state_q == IDLE && anyValid) begin
         if (selIdx == IDX_W'(N_EXT - 1)) begin
            rrPtr_d = '0;
         end else begin
            rrPtr_d = selIdx + 1'b1;
         end
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rrPtr_q <= '0;
      end else begin
         rrPtr_q <= rrPtr_d;
      end
   end
`else
   // Fixed priority: the lowest-indexed valid requester wins.
   always_comb begin
      anyValid = 1'b0;
      selIdx   = '0;
      for (int i = 0; i < N_EXT; i++) begin
         if (!anyValid && validReq[i]) begin
            anyValid = 1'b1;
            selIdx   = IDX_W'(i);
         end
      end
   end
`endif

   // Illegal requests are reported once per occurrence while idle; the
   // seen-mask keeps a held illegal request from pulsing every cycle and
   // clears as soon as the request drops or becomes legal.
   always_comb begin
      errPulse = '0;
      if (nRST && state_q == IDLE) begin
         errPulse = illegalReq & ~errSeen_q;
      end
      errSeen_d = illegalReq & (errSeen_q | errPulse);
   end

   // Arbiter FSM: next state, request latching and per-state outputs.
   always_comb begin
      state_d   = state_q;
      winIdx_d  = winIdx_q;
      addr_d    = addr_q;
      store_d   = store_q;
      ren_d     = ren_q;
      wen_d     = wen_q;
      load_d    = load_q;
      req_mem   = 1'b0;
      mem_ren   = 1'b0;
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_store = '0;
      ext_gnt   = '0;
      ext_done  = '0;
      case (state_q)
         IDLE: begin
            if (anyValid) begin
               state_d  = BUSY;
               winIdx_d = selIdx;
               addr_d   = ext_addr[32*selIdx +: 32];
               store_d  = ext_store[32*selIdx +: 32];
               ren_d    = ext_ren[selIdx];
               wen_d    = ext_wen[selIdx];
            end
         end
         BUSY: begin
            req_mem           = 1'b1;
            mem_ren           = ren_q;
            mem_wen           = wen_q;
            mem_addr          = addr_q;
            mem_store         = store_q;
            ext_gnt[winIdx_q] = 1'b1;
            if (!mem_busy) begin
               if (ren_q) begin
                  load_d = mem_load;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            ext_done[winIdx_q] = 1'b1;
            state_d            = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched-request registers; reset abandons any access.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         winIdx_q  <= '0;
         addr_q    <= '0;
         store_q   <= '0;
         ren_q     <= 1'b0;
         wen_q     <= 1'b0;
         load_q    <= '0;
         errSeen_q <= '0;
      end else begin
         state_q   <= state_d;
         winIdx_q  <= winIdx_d;
         addr_q    <= addr_d;
         store_q   <= store_d;
         ren_q     <= ren_d;
         wen_q     <= wen_d;
         load_q    <= load_d;
         errSeen_q <= errSeen_d;
      end
   end

   // Stall whenever an access is outstanding or about to be granted;
   // forced low while reset is asserted.
   always_comb begin
      memory_stall = nRST & ((state_q != IDLE) | anyValid);
      ext_err      = errPulse;
      ext_load     = load_q;
   end

endmodule
